// File: rtl/partoserial.sv
// Byte-to-serial transmitter: MSB-first, one bit per clk_8f, comma fill on idle slots, comma training burst after reset.
// Optional: define COMMA_DROP_EN to consume accepted COMMA bytes without sending them and pulse err_comma.
module partoserial #(
  parameter logic [7:0]  COMMA     = 8'hBC,
  parameter int unsigned TRAIN_CNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       out,
  output logic       active,
  output logic       err_comma
);

  typedef enum logic {TRAIN, RUN} state_t;

  localparam logic [3:0] TRAIN_LIM = 4'(TRAIN_CNT);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] train_cnt_q, train_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       err_q, err_d;

  logic boundary;
  logic xfer;
  logic drop;

  assign boundary  = (bit_cnt_q == 3'd7);
  assign ready_out = !hold_full_q || (boundary && state_q == RUN);
  assign xfer      = valid_in && ready_out;

`ifdef COMMA_DROP_EN
  assign drop = xfer && (data_in == COMMA);
`else
  assign drop = 1'b0;
`endif

  assign out       = shift_q[7];
  assign active    = (state_q == RUN);
  assign err_comma = err_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = {shift_q[6:0], 1'b0};
    bit_cnt_d   = bit_cnt_q + 3'd1;
    train_cnt_d = train_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    err_d       = drop;

    if (boundary) begin
      bit_cnt_d = 3'd0;
      if (state_q == TRAIN) begin
        shift_d     = COMMA;
        train_cnt_d = train_cnt_q + 4'd1;
        if (train_cnt_q + 4'd1 == TRAIN_LIM) begin
          state_d = RUN;
        end
      end else if (hold_full_q) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        shift_d = COMMA;
      end
    end

    // A byte accepted on the same edge the hold drains refills it, so no comma gap appears.
    if (xfer && !drop) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= TRAIN;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd7;
      train_cnt_q <= 4'd0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      train_cnt_q <= train_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_partoserial.sv
// Self-checking bench for partoserial: randomized and directed stimulus against a symbol-level reference model.
module tb_partoserial;

  localparam logic [7:0]  COMMA     = 8'hBC;
  localparam int unsigned TRAIN_CNT = 4;

  logic       clk_8f = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, out, active, err_comma;

  int checks = 0;
  int errors = 0;

  partoserial #(.COMMA(COMMA), .TRAIN_CNT(TRAIN_CNT)) dut (
    .clk_8f    (clk_8f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .out       (out),
    .active    (active),
    .err_comma (err_comma)
  );

  always #5 clk_8f = ~clk_8f;

  // Reference model: e counts edges since reset release; edges 0,8,16.. start a new symbol.
  int unsigned e;
  logic [7:0]  sym;
  logic [7:0]  hold;
  bit          hfull;
  bit          eerr;
  bit          acc;
  bit          pending;
  int unsigned n_data_sent;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  function automatic bit run_at(input int unsigned idx);
    return ((idx + 7) / 8) >= TRAIN_CNT;
  endfunction

  function automatic bit ready_exp();
    return !hfull || ((e % 8 == 0) && run_at(e));
  endfunction

  task automatic model_reset();
    e = 0; sym = 8'h00; hold = 8'h00; hfull = 0; eerr = 0; pending = 0;
  endtask

  task automatic model_edge();
    bit bnd, run, rdy;
    bnd = (e % 8 == 0);
    run = run_at(e);
    rdy = ready_exp();
    acc = valid_in && rdy;
    eerr = 0;
    if (bnd) begin
      if (run && hfull) begin
        sym = hold;
        hfull = 0;
        n_data_sent++;
      end else begin
        sym = COMMA;
      end
    end
    if (acc) begin
`ifdef COMMA_DROP_EN
      if (data_in == COMMA) eerr = 1;
      else begin hold = data_in; hfull = 1; end
`else
      hold = data_in; hfull = 1;
`endif
    end
    e++;
  endtask

  task automatic check_outputs();
    logic [7:0] s;
    int unsigned bi;
    s = sym;
    bi = 7 - ((e - 1) % 8);
    check("out", {31'd0, out}, (e == 0) ? 32'd0 : {31'd0, s[bi]});
    check("active", {31'd0, active}, {31'd0, run_at(e)});
    check("ready_out", {31'd0, ready_out}, {31'd0, ready_exp()});
    check("err_comma", {31'd0, err_comma}, {31'd0, eerr});
  endtask

  task automatic step();
    @(posedge clk_8f);
    model_edge();
    @(negedge clk_8f);
    check_outputs();
    if (acc) pending = 0;
  endtask

  // Asserts reset asynchronously mid-cycle, checks reset values, releases on a falling edge.
  task automatic do_reset();
    #2;
    valid_in = 0;
    reset_L = 0;
    #1;
    check("rst_out", {31'd0, out}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_ready", {31'd0, ready_out}, 32'd1);
    check("rst_err", {31'd0, err_comma}, 32'd0);
    @(posedge clk_8f);
    @(negedge clk_8f);
    check("rst_hold_out", {31'd0, out}, 32'd0);
    reset_L = 1;
    model_reset();
  endtask

  // mode 0: idle, 1: random bytes, 2: incrementing bytes held back-to-back
  task automatic run_cycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      if (!pending) begin
        if (mode == 2) begin
          pending = 1;
          data_in = data_in + 8'd1;
        end else if (mode == 1 && ($urandom % 3 != 0)) begin
          pending = 1;
          data_in = ($urandom % 5 == 0) ? COMMA : 8'($urandom);
        end
      end
      valid_in = pending;
      step();
    end
    valid_in = 0;
  endtask

  initial begin
    bit found;
    model_reset();
    n_data_sent = 0;
    @(negedge clk_8f);
    do_reset();

    // Idle training and comma fill
    run_cycles(48, 0);

    // 0xA5 presented during training at edge 2
    do_reset();
    data_in = 8'hA5;
    for (int i = 0; i < 48; i++) begin
      valid_in = (e >= 2) && (n_data_sent == 0) && !hfull && (i < 8);
      step();
    end
    valid_in = 0;
    check("a5_sent", n_data_sent, 1);

    // Back-to-back 0x01, 0x02, 0x03 in RUN
    data_in = 8'h00;
    pending = 0;
    run_cycles(24, 2);
    pending = 0;
    run_cycles(24, 0);

    // Single 0x5A three cycles after a boundary, then a raw COMMA byte
    while (e % 8 != 3) step();
    data_in = 8'h5A; pending = 1;
    run_cycles(1, 0);
    run_cycles(20, 0);
    while (e % 8 != 2) step();
    data_in = COMMA; pending = 1;
    run_cycles(1, 0);
    run_cycles(20, 0);

    // Random traffic
    run_cycles(600, 1);

    // Reset at bit 4 of a data symbol with the hold full
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (hfull && run_at(e) && e > 0 && ((e - 1) % 8 == 4) && sym != COMMA) found = 1;
      else run_cycles(1, 1);
    end
    check("midreset_found", {31'd0, found}, 32'd1);
    pending = 0;
    do_reset();
    data_in = 8'h3C; pending = 1;
    run_cycles(60, 0);
    run_cycles(300, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/partoserial.md
Name: partoserial

Overview:
- Transmit-side neighbour of the serial-to-parallel receiver in the PHY.
- Accepts bytes through a valid/ready handshake, serializes them MSB-first on one output bit per clk_8f cycle, and fills idle symbol slots with the comma symbol.
- After reset, sends a training burst of at least TRAIN_CNT commas so the downstream receiver can lock onto symbol boundaries before any data is sent.

Parameters:
- COMMA, 8'hBC: idle/training symbol.
- TRAIN_CNT, 4: number of commas loaded after reset before data may be sent; range 1..15.

Ports:
- clk_8f, input, 1: bit clock. All logic is on the rising edge.
- reset_L, input, 1: asynchronous, active-low reset.
- data_in, input, 8: parallel byte to transmit.
- valid_in, input, 1: data_in is valid.
- ready_out, output, 1: block can accept data_in this cycle.
- out, output, 1: serial data, MSB first, one bit per clk_8f.
- active, output, 1: training complete (state RUN).
- err_comma, output, 1: one-cycle pulse when an accepted byte equals COMMA and is dropped. Tied 0 unless COMMA_DROP_EN is defined.

Behaviour:
- Reset values (async, while reset_L=0):
  - out=0, active=0, err_comma=0, ready_out=1.
  - shift_reg=0, bit_cnt=7, train_cnt=0.
  - hold buffer empty, state=TRAIN.
- Reset mid-symbol or mid-training: the partial symbol and any held byte are discarded. Training restarts from zero.
- Symbol boundary:
  - A boundary is any rising edge where bit_cnt==7.
  - At a boundary, bit_cnt wraps to 0 and shift_reg loads the next symbol.
  - At all other edges, shift_reg shifts left by 1 and bit_cnt increments.
- out is always shift_reg[7]. The first boundary is the first rising edge after reset_L deasserts.
- State TRAIN:
  - Each boundary loads COMMA and increments train_cnt.
  - At the boundary where train_cnt becomes TRAIN_CNT, state moves to RUN and active rises.
  - A byte may be accepted into hold during TRAIN; it waits there.
- State RUN:
  - At a boundary, if hold is full, load hold and mark it empty.
  - Otherwise load COMMA.
  - RUN is left only by reset.
- Handshake:
  - ready_out = !hold_full || (boundary && state==RUN). This is combinational from registers.
  - A transfer occurs on a rising edge where valid_in && ready_out.
  - If the hold is freed and a new byte is accepted at the same boundary, the hold stays full with the new byte. The stream continues with no comma gap.
  - valid_in with ready_out=0 is ignored. data_in must be held stable by the source.
- Latency:
  - A byte accepted into an empty hold in RUN appears on out starting at the next boundary, 1..8 cycles later.
  - It occupies out for exactly 8 cycles.
- Back-to-back sustained throughput: 1 byte per 8 cycles.

Optional Feature:
- COMMA_DROP_EN defined:
  - An accepted byte equal to COMMA is consumed: ready_out is honoured and the transfer completes.
  - The byte is not written to hold.
  - err_comma pulses high for that cycle, registered on the next edge.
- COMMA_DROP_EN not defined:
  - Such a byte is transmitted verbatim. The receiver will count it as a comma.
  - err_comma is constant 0.

Test Plan:
- Reset release, valid_in=0: out shows 10111100 repeated.
  - active rises at the 4th boundary (cycle 24 after the first boundary at cycle 0).
  - Commas continue indefinitely; ready_out stays 1.
- 0xA5 presented during TRAIN at cycle 2:
  - Accepted at cycle 2; ready_out=0 until cycle 32.
  - Bits 10100101 appear at cycles 32..39, followed by commas.
- In RUN, valid_in held with 0x01, 0x02, 0x03 advanced on each transfer:
  - Contiguous output 00000001 00000010 00000011 with no comma between them.
  - ready_out is high only at boundaries once the hold is full.
- In RUN, 0x5A accepted 3 cycles after a boundary:
  - out=01011010 during boundary+8 .. boundary+15.
  - Then 10111100 follows.
- reset_L pulsed low at bit 4 of a data symbol with the hold full:
  - out=0 immediately, the hold is dropped, active=0.
  - 4 fresh commas are sent before any data.
- COMMA_DROP_EN defined, 0xBC sent in RUN:
  - Transfer completes and err_comma pulses 1 cycle.
  - Only commas are transmitted and the hold stays empty.
  - Without the macro, the byte is sent as 10111100 and err_comma=0.
